// File: rtl/dcache_responder_if.sv
// Datapath/memory-side signal bundle for dcache_responder; slave = cache view, master = driver/environment view.
interface dcache_responder_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        halt;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped write-back D-cache: hits answer same cycle, misses take 1+WB+FETCH cycles, all stalls on dwait.
// On halt, dirty lines are flushed in index order; DCACHE_STATS_EN adds a final hits-minus-misses write.
module dcache_responder #(
  parameter int          SETS       = 16,
  parameter int          IDX_W      = $clog2(SETS),
  parameter logic [31:0] STATS_ADDR = 32'h0000_3100
) (
  input logic               CLK,
  input logic               nRST,
  dcache_responder_if.slave dif
);

  localparam int               TAG_W    = 32 - IDX_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

  typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, STATS, HALTED} state_t;

  state_t state, next_state;

  logic [SETS-1:0]  valid;
  logic [SETS-1:0]  dirty;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_idx;
  logic [IDX_W-1:0] flush_idx;

  logic             req;
  logic             req_wr;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic             hit;
  logic             serve;
  logic             do_hit;
  logic             victim_dirty;
  logic             flush_dirty;
  logic             miss_start;

  assign req          = dif.dmemREN | dif.dmemWEN;
  assign req_wr       = dif.dmemWEN;
  assign req_tag      = dif.dmemaddr[31:IDX_W+2];
  assign req_idx      = dif.dmemaddr[IDX_W+1:2];
  assign hit          = valid[req_idx] && (tag_q[req_idx] == req_tag);
  // halt wins over any request, so a halted datapath never sees a hit
  assign serve        = (state == IDLE) && !dif.halt && req;
  assign do_hit       = serve && hit;
  assign victim_dirty = valid[req_idx] & dirty[req_idx];
  assign flush_dirty  = valid[flush_idx] & dirty[flush_idx];
  assign miss_start   = serve && !hit;

  logic unused_ok;
  assign unused_ok = ^dif.dmemaddr[1:0];

  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (dif.halt)       next_state = FLUSH;
        else if (miss_start) next_state = victim_dirty ? WB : FETCH;
      end
      WB:     if (!dif.dwait) next_state = FETCH;
      FETCH:  if (!dif.dwait) next_state = IDLE;
      FLUSH: begin
        if ((!flush_dirty || !dif.dwait) && (flush_idx == LAST_IDX)) begin
`ifdef DCACHE_STATS_EN
          next_state = STATS;
`else
          next_state = HALTED;
`endif
        end
      end
      STATS:  if (!dif.dwait) next_state = HALTED;
      HALTED: next_state = HALTED;
      default: next_state = IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hits;
  logic [31:0] misses;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hits   <= '0;
      misses <= '0;
    end else begin
      if (do_hit)     hits   <= hits + 32'd1;
      if (miss_start) misses <= misses + 32'd1;
    end
  end
`else
  logic [31:0] unused_stats_addr;
  assign unused_stats_addr = STATS_ADDR;
`endif

  always_comb begin
    dif.dhit     = 1'b0;
    dif.dmemload = '0;
    dif.dREN     = 1'b0;
    dif.dWEN     = 1'b0;
    dif.daddr    = '0;
    dif.dstore   = '0;
    dif.flushed  = 1'b0;
    case (state)
      IDLE: begin
        if (do_hit) begin
          dif.dhit = 1'b1;
          if (!req_wr) dif.dmemload = data_q[req_idx];
        end
      end
      WB: begin
        dif.dWEN   = 1'b1;
        dif.daddr  = {tag_q[miss_idx], miss_idx, 2'b00};
        dif.dstore = data_q[miss_idx];
      end
      FETCH: begin
        dif.dREN  = 1'b1;
        dif.daddr = {miss_tag, miss_idx, 2'b00};
      end
      FLUSH: begin
        if (flush_dirty) begin
          dif.dWEN   = 1'b1;
          dif.daddr  = {tag_q[flush_idx], flush_idx, 2'b00};
          dif.dstore = data_q[flush_idx];
        end
      end
      STATS: begin
`ifdef DCACHE_STATS_EN
        dif.dWEN   = 1'b1;
        dif.daddr  = STATS_ADDR;
        dif.dstore = hits - misses;
`endif
      end
      HALTED:  dif.flushed = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid     <= '0;
      dirty     <= '0;
      flush_idx <= '0;
      miss_tag  <= '0;
      miss_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (do_hit && req_wr) begin
            data_q[req_idx] <= dif.dmemstore;
            dirty[req_idx]  <= 1'b1;
          end
          // the fill follows this latched address even if the request changes
          if (miss_start) begin
            miss_tag <= req_tag;
            miss_idx <= req_idx;
          end
        end
        WB: if (!dif.dwait) dirty[miss_idx] <= 1'b0;
        FETCH: begin
          if (!dif.dwait) begin
            valid[miss_idx]  <= 1'b1;
            dirty[miss_idx]  <= 1'b0;
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= dif.dload;
          end
        end
        FLUSH: begin
          if (!flush_dirty || !dif.dwait) begin
            dirty[flush_idx] <= 1'b0;
            flush_idx        <= flush_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Data-side responder for the datapath/cache interface. It accepts dmemREN/dmemWEN requests from the pipeline and answers with dhit and dmemload.
- Direct-mapped, one-word-block, write-back, write-allocate cache between the datapath and the memory controller.
- On halt it writes back every dirty line, then asserts flushed so the system can stop.

Parameters:
- SETS, 16, number of cache lines; power of 2, minimum 2.
- IDX_W, $clog2(SETS), index width.
- STATS_ADDR, 32'h00003100, word address for the hit/miss statistic (optional feature only).

Ports:
- CLK  in  1  clock
- nRST  in  1  reset; synchronous, active-low, sampled on posedge CLK
- dmemREN  in  1  datapath read request
- dmemWEN  in  1  datapath write request
- dmemaddr  in  32  request byte address; bits [1:0] ignored
- dmemstore  in  32  write data
- halt  in  1  datapath halted (sticky from datapath)
- dhit  out  1  request serviced this cycle
- dmemload  out  32  read data; valid when dhit=1
- flushed  out  1  flush complete (sticky)
- dREN  out  1  memory read request
- dWEN  out  1  memory write request
- daddr  out  32  memory address, word aligned
- dstore  out  32  memory write data
- dwait  in  1  memory busy; transfer completes in the cycle dwait=0
- dload  in  32  memory read data, valid when dwait=0

Behaviour:
- Address split: tag = [31:IDX_W+2], idx = [IDX_W+1:2].
- Per line storage: valid, dirty, tag, data. All valid and dirty bits clear at reset.
- Reset (nRST=0 at posedge), including mid-transfer:
  - state <= IDLE, flush counter <= 0, flushed <= 0.
  - All valid/dirty bits cleared; next cycle dREN=dWEN=0, daddr=0, dstore=0.
- Outputs: dhit=0 and dmemload=0 whenever not in IDLE or no request is present.
- IDLE:
  - Request = dmemREN|dmemWEN. If both are high, treat as a write.
  - Hit (valid & tag match): dhit=1 combinationally in the same cycle.
    - Read: dmemload = line data.
    - Write: at posedge, data <= dmemstore and dirty <= 1.
  - Miss: if victim is valid & dirty -> WB, else -> FETCH. dhit stays 0.
  - halt=1 has priority over any request -> FLUSH; requests are ignored thereafter.
- WB:
  - dWEN=1, daddr={victim tag, idx, 2'b00}, dstore=victim data.
  - Hold outputs while dwait=1. On dwait=0: dirty <= 0, -> FETCH.
- FETCH:
  - dREN=1, daddr={req tag, idx, 2'b00}.
  - On dwait=0: valid <= 1, tag <= req tag, data <= dload, dirty <= 0, -> IDLE.
  - The retried request hits in the next cycle. A write miss therefore fills first, then writes on the hit.
- Miss latency: 1 + (WB cycles) + (FETCH cycles) before the dhit cycle.
- FLUSH:
  - Counter i from 0 to SETS-1. If line i is valid & dirty: dWEN=1, daddr={tag_i, i, 2'b00}, dstore=data_i. On dwait=0: clear dirty, i++.
  - Clean lines are skipped at 1 cycle each.
  - After i=SETS-1 completes -> STATS (if enabled) else HALTED. Counter wrap is never used.
- HALTED: flushed=1, no memory traffic. Exit only via reset.
- Request inputs changing mid-miss are not tracked. The FSM completes the fill for the index/tag latched on entry to WB/FETCH. Latch the request address on the miss transition.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- With the macro defined:
  - 32-bit hits counter: +1 per cycle with dhit=1.
  - 32-bit misses counter: +1 per IDLE->WB/FETCH transition.
  - Both counters reset to 0.
  - After FLUSH, STATS state: dWEN=1, daddr=STATS_ADDR, dstore=hits-misses (mod 2^32). Hold until dwait=0, then -> HALTED.
- Without the macro: no counters, FLUSH goes directly to HALTED, and STATS_ADDR is unused.

Test Plan:
- Read miss then hit:
  - Read 0x0000_0040 with memory returning 0xDEADBEEF after 2 dwait cycles -> dREN, daddr=0x40.
  - Next cycle dhit=1, dmemload=0xDEADBEEF. Repeat read -> same-cycle dhit, no memory traffic.
- Write hit marks dirty:
  - Write 0x12345678 to 0x40 after fill -> dhit=1 same cycle.
  - Then read 0x440 (same idx, SETS=16) -> WB dWEN daddr=0x40 dstore=0x12345678, then FETCH daddr=0x440.
- dwait stretching: hold dwait=1 for 5 cycles in WB -> dWEN/daddr/dstore stable all 5 cycles; state advances only on dwait=0.
- Halt flush:
  - Dirty lines at idx 3 (0x0C, 0xAAAA) and idx 9 (0x124, 0xBBBB), then halt=1.
  - Exactly two writebacks in index order: 0x0C then 0x124. Then flushed=1, no further dREN/dWEN.
- Stats (DCACHE_STATS_EN): 3 hits, 2 misses, halt -> final write daddr=0x3100, dstore=0x00000001, then flushed=1.
- Reset mid-FETCH: nRST=0 for one edge while dREN=1 -> next cycle dREN=0, flushed=0. A read to the previously filled address misses again.
